obb_bank: RTL

Multi-body successor to the single-OBB state register: holds `N_BODIES` oriented-bounding-box physics records in one bank. It provides two registered read ports for collision-pair lookup and one masked write port for integrator and solver updates. After reset, an init sequencer walks the entries and loads a spawn layout. An optional frame double-buffer isolates in-frame writes from readers until a `commit` strobe.

---
 rtl/obb_pkg.sv | 68 ++++++
 rtl/obb_field_merge.sv | 32 +++
 rtl/obb_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/obb_pkg.sv
// obb_pkg -- shared types and helpers for the oriented-bounding-box bank.
//   obb_t        : packed physics record (kinematics, rotation, mass properties)
//   POS_FRAC     : fractional bits of pos_x/pos_y (fixed point)
//   INV_*_FRAC   : fractional bits of the reciprocal fields
//   WM_*         : bit positions inside the 3-bit write mask
//   idx_w()      : index width for a given number of bodies
//   inv_scaled() : fixed-point reciprocal, zero for a zero divisor
//   obb_spawn()  : spawn record for entry idx
package obb_pkg;

  localparam int POS_W            = 16;
  localparam int POS_FRAC         = 4;
  localparam int VEL_W            = 16;
  localparam int ANG_W            = 16;
  localparam int OMEGA_W          = 16;
  localparam int DIM_W            = 8;
  localparam int MASS_W           = 8;
  localparam int INERTIA_W        = 16;
  localparam int INV_W            = 16;
  localparam int INV_MASS_FRAC    = 12;
  localparam int INV_INERTIA_FRAC = 12;

  localparam int WM_KIN   = 0;
  localparam int WM_ROT   = 1;
  localparam int WM_MASSP = 2;

  typedef struct packed {
    logic [POS_W-1:0]     pos_x;
    logic [POS_W-1:0]     pos_y;
    logic [VEL_W-1:0]     vel_x;
    logic [VEL_W-1:0]     vel_y;
    logic [ANG_W-1:0]     angle;
    logic [OMEGA_W-1:0]   omega;
    logic [DIM_W-1:0]     width;
    logic [DIM_W-1:0]     height;
    logic [MASS_W-1:0]    mass;
    logic [INV_W-1:0]     inv_mass;
    logic [INERTIA_W-1:0] inertia;
    logic [INV_W-1:0]     inv_inertia;
  } obb_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int inv_scaled(input int v, input int frac);
    return (v == 0) ? 0 : ((1 << frac) / v);
  endfunction

  // Inertia and reciprocals are passed in already evaluated from parameters,
  // so the only run-time arithmetic here is the x offset of entry idx.
  function automatic obb_t obb_spawn(input int idx, input int x_base, input int x_step,
                                     input int y_init, input int w, input int h, input int m,
                                     input int inertia, input int inv_m, input int inv_i);
    obb_t s;
    s             = '0;
    s.pos_x       = POS_W'((x_base + idx * x_step) << POS_FRAC);
    s.pos_y       = POS_W'(y_init << POS_FRAC);
    s.width       = DIM_W'(w);
    s.height      = DIM_W'(h);
    s.mass        = MASS_W'(m);
    s.inv_mass    = INV_W'(inv_m);
    s.inertia     = INERTIA_W'(inertia);
    s.inv_inertia = INV_W'(inv_i);
    return s;
  endfunction

endpackage

// File: rtl/obb_field_merge.sv
// obb_field_merge -- combinational masked merge of two obb_t records.
//   i_old    : current record
//   i_new    : incoming record
//   i_mask   : [WM_KIN] pos/vel, [WM_ROT] angle/omega, [WM_MASSP] mass properties
//   o_merged : i_new fields for selected groups, i_old fields elsewhere
module obb_field_merge
  import obb_pkg::*;
(
  input  obb_t       i_old,
  input  obb_t       i_new,
  input  logic [2:0] i_mask,
  output obb_t       o_merged
);

  // Per-group field select.
  always_comb begin
    o_merged             = i_old;
    o_merged.pos_x       = i_mask[WM_KIN]   ? i_new.pos_x       : i_old.pos_x;
    o_merged.pos_y       = i_mask[WM_KIN]   ? i_new.pos_y       : i_old.pos_y;
    o_merged.vel_x       = i_mask[WM_KIN]   ? i_new.vel_x       : i_old.vel_x;
    o_merged.vel_y       = i_mask[WM_KIN]   ? i_new.vel_y       : i_old.vel_y;
    o_merged.angle       = i_mask[WM_ROT]   ? i_new.angle       : i_old.angle;
    o_merged.omega       = i_mask[WM_ROT]   ? i_new.omega       : i_old.omega;
    o_merged.width       = i_mask[WM_MASSP] ? i_new.width       : i_old.width;
    o_merged.height      = i_mask[WM_MASSP] ? i_new.height      : i_old.height;
    o_merged.mass        = i_mask[WM_MASSP] ? i_new.mass        : i_old.mass;
    o_merged.inv_mass    = i_mask[WM_MASSP] ? i_new.inv_mass    : i_old.inv_mass;
    o_merged.inertia     = i_mask[WM_MASSP] ? i_new.inertia     : i_old.inertia;
    o_merged.inv_inertia = i_mask[WM_MASSP] ? i_new.inv_inertia : i_old.inv_inertia;
  end

endmodule

// File: rtl/obb_bank.sv
// obb_bank -- bank of N_BODIES oriented-bounding-box records.
//   clk, reset           : clock, synchronous active-high reset
//   init_busy            : spawn-layout loader running
//   rd_a_idx / rd_a_data : read port A (1-cycle registered, zero when idx out of range)
//   rd_b_idx / rd_b_data : read port B (same)
//   wr_en/wr_idx/wr_mask/wr_data : masked write port
//   commit / commit_done : end-of-frame strobe and its one-cycle acknowledge
// Optional feature: define OBB_BANK_DOUBLE_BUF_EN for a shadow bank that
// collects writes and is copied into the live bank on commit.
module obb_bank
  import obb_pkg::*;
#(
  parameter int N_BODIES    = 4,
  parameter int X_INIT_BASE = 32,
  parameter int X_INIT_STEP = 64,
  parameter int Y_INIT      = 32,
  parameter int WIDTH_INIT  = 10,
  parameter int HEIGHT_INIT = 10,
  parameter int MASS_INIT   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         init_busy,
  input  logic [idx_w(N_BODIES)-1:0]   rd_a_idx,
  output obb_t                         rd_a_data,
  input  logic [idx_w(N_BODIES)-1:0]   rd_b_idx,
  output obb_t                         rd_b_data,
  input  logic                         wr_en,
  input  logic [idx_w(N_BODIES)-1:0]   wr_idx,
  input  logic [2:0]                   wr_mask,
  input  obb_t                         wr_data,
  input  logic                         commit,
  output logic                         commit_done
);

  localparam int IW               = idx_w(N_BODIES);
  localparam int INERTIA_INIT     = MASS_INIT * (WIDTH_INIT * WIDTH_INIT + HEIGHT_INIT * HEIGHT_INIT) / 12;
  localparam int INV_MASS_INIT    = inv_scaled(MASS_INIT, INV_MASS_FRAC);
  localparam int INV_INERTIA_INIT = inv_scaled(INERTIA_INIT, INV_INERTIA_FRAC);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_INIT  = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BODIES - 1);

  logic [0:0]    r_state;
  logic [IW-1:0] r_cnt;
  logic          r_init_busy;
  logic          r_commit_done;
  obb_t          r_rd_a;
  obb_t          r_rd_b;
  obb_t          r_live [N_BODIES];

  logic w_idle;
  logic w_wr_idx_ok;
  logic w_wr_go;
  logic w_commit_go;
  logic w_rd_a_ok;
  logic w_rd_b_ok;
  obb_t w_spawn;
  obb_t w_wr_old;
  obb_t w_wr_merged;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_wr_idx_ok = (32'(wr_idx) < 32'(N_BODIES));
  assign w_rd_a_ok   = (32'(rd_a_idx) < 32'(N_BODIES));
  assign w_rd_b_ok   = (32'(rd_b_idx) < 32'(N_BODIES));
  // Host writes and commits are only honoured once the loader has finished.
  assign w_wr_go     = wr_en && w_idle && !reset && w_wr_idx_ok && (wr_mask != 3'b000);
  assign w_commit_go = commit && w_idle && !reset;
  assign w_spawn     = obb_spawn(32'(r_cnt), X_INIT_BASE, X_INIT_STEP, Y_INIT, WIDTH_INIT,
                                 HEIGHT_INIT, MASS_INIT, INERTIA_INIT, INV_MASS_INIT,
                                 INV_INERTIA_INIT);

  // The same merged record feeds the write target and, with the double
  // buffer, the commit-forward path (a write in the commit cycle lands live).
  obb_field_merge u_wr_merge (
    .i_old    (w_wr_old),
    .i_new    (wr_data),
    .i_mask   (wr_mask),
    .o_merged (w_wr_merged)
  );

  // Init sequencer: walks entries 0..N_BODIES-1 after every reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
    end else if (r_state == ST_INIT) begin
      if (r_cnt == LAST_IDX) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_init_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + IW'(1);
      end
    end
  end

`ifdef OBB_BANK_DOUBLE_BUF_EN
  obb_t r_shadow [N_BODIES];

  assign w_wr_old = w_wr_idx_ok ? r_shadow[wr_idx] : '0;

  // Shadow bank: receives spawn records and all frame writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_shadow[r_cnt] <= w_spawn;
    end else if (w_wr_go) begin
      r_shadow[wr_idx] <= w_wr_merged;
    end
  end

  // Live bank: spawn records, or a full copy of shadow on commit.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_live[r_cnt] <= w_spawn;
    end else if (w_commit_go) begin
      for (int j = 0; j < N_BODIES; j++) begin
        r_live[j] <= (w_wr_go && (wr_idx == IW'(j))) ? w_wr_merged : r_shadow[j];
      end
    end
  end
`else
  assign w_wr_old = w_wr_idx_ok ? r_live[wr_idx] : '0;

  // Live bank: spawn records, then direct masked writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_live[r_cnt] <= w_spawn;
    end else if (w_wr_go) begin
      r_live[wr_idx] <= w_wr_merged;
    end
  end
`endif

  // Registered read ports and commit acknowledge; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_a        <= '0;
      r_rd_b        <= '0;
      r_commit_done <= 1'b0;
    end else begin
      r_rd_a        <= w_rd_a_ok ? r_live[rd_a_idx] : '0;
      r_rd_b        <= w_rd_b_ok ? r_live[rd_b_idx] : '0;
      r_commit_done <= w_commit_go;
    end
  end

  assign init_busy   = r_init_busy;
  assign rd_a_data   = r_rd_a;
  assign rd_b_data   = r_rd_b;
  assign commit_done = r_commit_done;

endmodule
